// File: rtl/lc3b_defs.sv
// lc3b_defs: shared definitions for the LC-3b microsequencer.
//   - state_e   : microsequencer state numbers (fetch, execute, memory, error)
//   - encodings : ALU function, PC mux and ADDR2 mux select values
//   - ctrl_t    : bundle of every datapath/memory control the sequencer drives
//   - helpers   : memory-state classification, memory exit state,
//                 reserved-opcode test and ctrl_t builders for shared states
package lc3b_defs;

  typedef enum logic [5:0] {
    S_BR        = 6'd0,
    S_ADD       = 6'd1,
    S_LDB       = 6'd2,
    S_STB       = 6'd3,
    S_JSR       = 6'd4,
    S_AND       = 6'd5,
    S_LDW       = 6'd6,
    S_STW       = 6'd7,
    S_XOR       = 6'd9,
    S_JMP       = 6'd12,
    S_SHF       = 6'd13,
    S_LEA       = 6'd14,
    S_TRAP      = 6'd15,
    S_STW_MEM   = 6'd16,
    S_STB_MEM   = 6'd17,
    S_FETCH0    = 6'd18,
    S_JSR_PC    = 6'd19,
    S_JSRR_LINK = 6'd20,
    S_JSR_LINK  = 6'd21,
    S_BR_TAKEN  = 6'd22,
    S_STW_MDR   = 6'd23,
    S_STB_MDR   = 6'd24,
    S_LDW_MEM   = 6'd25,
    S_LDW_WB    = 6'd27,
    S_TRAP_MEM  = 6'd28,
    S_LDB_MEM   = 6'd29,
    S_TRAP_PC   = 6'd30,
    S_LDB_WB    = 6'd31,
    S_DECODE    = 6'd32,
    S_FETCH1    = 6'd33,
    S_FETCH2    = 6'd35,
    S_ERR       = 6'd63
  } state_e;

  // Reserved opcodes that trap to the error state.
  localparam logic [3:0] OP_RSV8  = 4'd8;
  localparam logic [3:0] OP_RSV10 = 4'd10;
  localparam logic [3:0] OP_RSV11 = 4'd11;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_XOR   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  localparam logic [1:0] PCMUX_PC2   = 2'd0;
  localparam logic [1:0] PCMUX_ADDER = 2'd1;
  localparam logic [1:0] PCMUX_BUS   = 2'd2;

  localparam logic [1:0] ADDR2_OFF11 = 2'd0;
  localparam logic [1:0] ADDR2_OFF9  = 2'd1;
  localparam logic [1:0] ADDR2_OFF6  = 2'd2;
  localparam logic [1:0] ADDR2_ZERO  = 2'd3;

  typedef struct packed {
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       sr2mux;
    logic       marmux;
    logic [1:0] aluk;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       ldmar;
    logic       ldmdr;
    logic       ldpc;
    logic       ldir;
    logic       ldreg;
    logic       ldcc;
    logic       gatepc;
    logic       gatemdr;
    logic       gatealu;
    logic       gateshf;
    logic       gatemarmux;
    logic       mio_en;
    logic       rw;
    logic       datasize;
    logic       lshf;
  } ctrl_t;

  // Every control low: the value of all unlisted controls in every state.
  localparam ctrl_t CTRL_IDLE = '0;

  // States that drive mio_en and wait on memory ready.
  function automatic logic is_mem_state(input state_e s);
    logic res;
    case (s)
      S_FETCH1, S_LDB_MEM, S_LDW_MEM,
      S_STB_MEM, S_STW_MEM, S_TRAP_MEM: res = 1'b1;
      default:                          res = 1'b0;
    endcase
    return res;
  endfunction

  // Successor of a memory state once r is seen.
  function automatic state_e mem_exit_state(input state_e s);
    state_e res;
    case (s)
      S_FETCH1:   res = S_FETCH2;
      S_LDB_MEM:  res = S_LDB_WB;
      S_LDW_MEM:  res = S_LDW_WB;
      S_STB_MEM:  res = S_FETCH0;
      S_STW_MEM:  res = S_FETCH0;
      S_TRAP_MEM: res = S_TRAP_PC;
      default:    res = S_ERR;
    endcase
    return res;
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == OP_RSV8) || (op == OP_RSV10) || (op == OP_RSV11);
  endfunction

  // Register-to-register ALU operation (ADD/AND/XOR), writing DR and CC.
  function automatic ctrl_t alu_ctrl(input logic [1:0] k, input logic [2:0] sr1,
                                     input logic [2:0] sr2, input logic [2:0] dr,
                                     input logic imm);
    ctrl_t c;
    c         = CTRL_IDLE;
    c.aluk    = k;
    c.sr1     = sr1;
    c.sr2     = sr2;
    c.dr      = dr;
    c.sr2mux  = imm;
    c.gatealu = 1'b1;
    c.ldreg   = 1'b1;
    c.ldcc    = 1'b1;
    return c;
  endfunction

  // MAR <- BaseR + off6 (shifted for word accesses), shared by loads/stores.
  function automatic ctrl_t addr_ctrl(input logic [2:0] base, input logic word);
    ctrl_t c;
    c            = CTRL_IDLE;
    c.sr1        = base;
    c.addr1mux   = 1'b1;
    c.addr2mux   = ADDR2_OFF6;
    c.lshf       = word;
    c.marmux     = 1'b1;
    c.gatemarmux = 1'b1;
    c.ldmar      = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/lc3b_cc_unit.sv
// lc3b_cc_unit: LC-3b condition-code registers.
//   clk_50, reset : clock and synchronous active-high reset (resets to n=0 z=1 p=0)
//   ldcc          : load strobe; when high at a rising edge n/z/p follow bus
//   bus           : datapath bus, WORD_W bits, MSB is the sign
//   n, z, p       : registered condition codes, exactly one is high
module lc3b_cc_unit #(
  parameter int WORD_W = 16
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              ldcc,
  input  logic [WORD_W-1:0] bus,
  output logic              n,
  output logic              z,
  output logic              p
);

  logic n_q, z_q, p_q;
  logic n_d, z_d, p_d;
  logic bus_zero_s;

  assign bus_zero_s = (bus == {WORD_W{1'b0}});

  // Next condition codes: classify the bus when loading, otherwise hold.
  always_comb begin
    n_d = n_q;
    z_d = z_q;
    p_d = p_q;
    if (ldcc) begin
      n_d = bus[WORD_W-1];
      z_d = bus_zero_s;
      p_d = ~bus[WORD_W-1] & ~bus_zero_s;
    end else begin
      n_d = n_q;
      z_d = z_q;
      p_d = p_q;
    end
  end

  // Condition-code registers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      n_q <= 1'b0;
      z_q <= 1'b1;
      p_q <= 1'b0;
    end else begin
      n_q <= n_d;
      z_q <= z_d;
      p_q <= p_d;
    end
  end

  assign n = n_q;
  assign z = z_q;
  assign p = p_q;

endmodule

// File: rtl/lc3b_microseq.sv
// lc3b_microseq: LC-3b Moore microsequencer.
//   clk_50, reset      : clock, synchronous active-high reset (to fetch state 18)
//   r                  : memory ready, only looked at in memory states
//   ir, bus            : instruction register and datapath bus (WORD_W bits)
//   pcmux..lshf        : datapath mux selects, loads, bus gates and memory controls,
//                        all decoded from the current state (plus IR fields)
//   n, z, p, ben       : registered condition codes and branch enable
//   state_o            : current state number
//   mem_err/illegal_op : sticky error cause while parked in ERR (63)
// MEM_TIMEOUT must be >= 2 and 2**CNT_W must exceed it.
module lc3b_microseq
  import lc3b_defs::*;
#(
  parameter int WORD_W      = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              r,
  input  logic [WORD_W-1:0] ir,
  input  logic [WORD_W-1:0] bus,
  output logic [1:0]        pcmux,
  output logic              addr1mux,
  output logic [1:0]        addr2mux,
  output logic              sr2mux,
  output logic              marmux,
  output logic [1:0]        aluk,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [2:0]        dr,
  output logic              ldmar,
  output logic              ldmdr,
  output logic              ldpc,
  output logic              ldir,
  output logic              ldreg,
  output logic              ldcc,
  output logic              gatepc,
  output logic              gatemdr,
  output logic              gatealu,
  output logic              gateshf,
  output logic              gatemarmux,
  output logic              mio_en,
  output logic              rw,
  output logic              datasize,
  output logic              lshf,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic              ben,
  output logic [5:0]        state_o,
  output logic              mem_err,
  output logic              illegal_op
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ben_q, ben_d;
  logic             mem_err_q, mem_err_d;
  logic             illegal_op_q, illegal_op_d;
  ctrl_t            ctrl_s;

  logic [3:0] opcode_s;
  logic [2:0] dst_s, base_s, src2_s;
  logic       imm_s;
  logic       unused_ir_bits;

  assign opcode_s       = ir[15:12];
  assign dst_s          = ir[11:9];
  assign base_s         = ir[8:6];
  assign imm_s          = ir[5];
  assign src2_s         = ir[2:0];
  assign unused_ir_bits = ^ir[4:3];

  // State register plus wait counter, branch enable and error flags.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q      <= S_FETCH0;
      cnt_q        <= {CNT_W{1'b0}};
      ben_q        <= 1'b0;
      mem_err_q    <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ben_q        <= ben_d;
      mem_err_q    <= mem_err_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Next-state logic. The wait counter is zero whenever a memory state is
  // (re)entered because every path except "stay and wait" loads zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = {CNT_W{1'b0}};
    ben_d        = ben_q;
    mem_err_d    = mem_err_q;
    illegal_op_d = illegal_op_q;
    if (is_mem_state(state_q)) begin
      if (r) begin
        state_d = mem_exit_state(state_q);
      end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d   = S_ERR;
        mem_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      case (state_q)
        S_FETCH0:  state_d = S_FETCH1;
        S_FETCH2:  state_d = S_DECODE;
        S_DECODE: begin
          ben_d = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
          if (is_illegal_op(opcode_s)) begin
            state_d      = S_ERR;
            illegal_op_d = 1'b1;
          end else begin
            // Execute state numbers equal the opcode.
            state_d = state_e'({2'b00, opcode_s});
          end
        end
        S_BR:        state_d = ben_q ? S_BR_TAKEN : S_FETCH0;
        S_JSR:       state_d = ir[11] ? S_JSR_LINK : S_JSRR_LINK;
        S_JSR_LINK,
        S_JSRR_LINK: state_d = S_JSR_PC;
        S_LDB:       state_d = S_LDB_MEM;
        S_LDW:       state_d = S_LDW_MEM;
        S_STB:       state_d = S_STB_MDR;
        S_STB_MDR:   state_d = S_STB_MEM;
        S_STW:       state_d = S_STW_MDR;
        S_STW_MDR:   state_d = S_STW_MEM;
        S_TRAP:      state_d = S_TRAP_MEM;
        S_ADD, S_AND, S_XOR, S_JMP, S_SHF, S_LEA, S_BR_TAKEN,
        S_JSR_PC, S_LDB_WB, S_LDW_WB, S_TRAP_PC:
                     state_d = S_FETCH0;
        S_ERR:       state_d = S_ERR;
        default:     state_d = S_ERR;
      endcase
    end
  end

  // Output decode: one control word per state, everything else idle.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state_q)
      S_FETCH0: begin
        ctrl_s.gatepc = 1'b1;
        ctrl_s.ldmar  = 1'b1;
        ctrl_s.ldpc   = 1'b1;
        ctrl_s.pcmux  = PCMUX_PC2;
      end
      S_FETCH1: begin
        ctrl_s.mio_en = 1'b1;
        ctrl_s.ldmdr  = 1'b1;
      end
      S_FETCH2: begin
        ctrl_s.gatemdr = 1'b1;
        ctrl_s.ldir    = 1'b1;
      end
      S_BR_TAKEN: begin
        ctrl_s.pcmux    = PCMUX_ADDER;
        ctrl_s.addr1mux = 1'b0;
        ctrl_s.addr2mux = ADDR2_OFF9;
        ctrl_s.ldpc     = 1'b1;
      end
      S_ADD: ctrl_s = alu_ctrl(ALUK_ADD, base_s, src2_s, dst_s, imm_s);
      S_AND: ctrl_s = alu_ctrl(ALUK_AND, base_s, src2_s, dst_s, imm_s);
      S_XOR: ctrl_s = alu_ctrl(ALUK_XOR, base_s, src2_s, dst_s, imm_s);
      S_JMP: begin
        ctrl_s.sr1     = base_s;
        ctrl_s.aluk    = ALUK_PASSA;
        ctrl_s.gatealu = 1'b1;
        ctrl_s.pcmux   = PCMUX_BUS;
        ctrl_s.ldpc    = 1'b1;
      end
      S_JSR_LINK, S_JSRR_LINK: begin
        ctrl_s.gatepc = 1'b1;
        ctrl_s.dr     = 3'd7;
        ctrl_s.ldreg  = 1'b1;
      end
      S_JSR_PC: begin
        ctrl_s.pcmux = PCMUX_ADDER;
        ctrl_s.ldpc  = 1'b1;
        // IR is stable for the whole instruction, so ir[11] still tells JSR from JSRR.
        if (ir[11]) begin
          ctrl_s.addr1mux = 1'b0;
          ctrl_s.addr2mux = ADDR2_OFF11;
        end else begin
          ctrl_s.addr1mux = 1'b1;
          ctrl_s.addr2mux = ADDR2_ZERO;
          ctrl_s.sr1      = base_s;
        end
      end
      S_SHF: begin
        ctrl_s.gateshf = 1'b1;
        ctrl_s.sr1     = base_s;
        ctrl_s.dr      = dst_s;
        ctrl_s.ldreg   = 1'b1;
        ctrl_s.ldcc    = 1'b1;
      end
      S_LEA: begin
        ctrl_s.lshf       = 1'b1;
        ctrl_s.addr1mux   = 1'b0;
        ctrl_s.addr2mux   = ADDR2_OFF9;
        ctrl_s.marmux     = 1'b1;
        ctrl_s.gatemarmux = 1'b1;
        ctrl_s.dr         = dst_s;
        ctrl_s.ldreg      = 1'b1;
      end
      S_LDB, S_STB: ctrl_s = addr_ctrl(base_s, 1'b0);
      S_LDW, S_STW: ctrl_s = addr_ctrl(base_s, 1'b1);
      S_LDB_MEM, S_LDW_MEM: begin
        ctrl_s.mio_en   = 1'b1;
        ctrl_s.ldmdr    = 1'b1;
        ctrl_s.datasize = (state_q == S_LDW_MEM);
      end
      S_LDB_WB, S_LDW_WB: begin
        ctrl_s.gatemdr = 1'b1;
        ctrl_s.dr      = dst_s;
        ctrl_s.ldreg   = 1'b1;
        ctrl_s.ldcc    = 1'b1;
      end
      S_STB_MDR, S_STW_MDR: begin
        ctrl_s.sr1     = dst_s;
        ctrl_s.aluk    = ALUK_PASSA;
        ctrl_s.gatealu = 1'b1;
        ctrl_s.ldmdr   = 1'b1;
      end
      S_STB_MEM, S_STW_MEM: begin
        ctrl_s.mio_en   = 1'b1;
        ctrl_s.rw       = 1'b1;
        ctrl_s.datasize = (state_q == S_STW_MEM);
      end
      S_TRAP: begin
        ctrl_s.marmux     = 1'b0;
        ctrl_s.gatemarmux = 1'b1;
        ctrl_s.ldmar      = 1'b1;
      end
      S_TRAP_MEM: begin
        ctrl_s.mio_en = 1'b1;
        ctrl_s.ldmdr  = 1'b1;
        ctrl_s.gatepc = 1'b1;
        ctrl_s.dr     = 3'd7;
        ctrl_s.ldreg  = 1'b1;
      end
      S_TRAP_PC: begin
        ctrl_s.gatemdr = 1'b1;
        ctrl_s.pcmux   = PCMUX_BUS;
        ctrl_s.ldpc    = 1'b1;
      end
      default: ctrl_s = CTRL_IDLE;
    endcase
  end

  lc3b_cc_unit #(.WORD_W(WORD_W)) u_cc (
    .clk_50 (clk_50),
    .reset  (reset),
    .ldcc   (ctrl_s.ldcc),
    .bus    (bus),
    .n      (n),
    .z      (z),
    .p      (p)
  );

  assign pcmux      = ctrl_s.pcmux;
  assign addr1mux   = ctrl_s.addr1mux;
  assign addr2mux   = ctrl_s.addr2mux;
  assign sr2mux     = ctrl_s.sr2mux;
  assign marmux     = ctrl_s.marmux;
  assign aluk       = ctrl_s.aluk;
  assign sr1        = ctrl_s.sr1;
  assign sr2        = ctrl_s.sr2;
  assign dr         = ctrl_s.dr;
  assign ldmar      = ctrl_s.ldmar;
  assign ldmdr      = ctrl_s.ldmdr;
  assign ldpc       = ctrl_s.ldpc;
  assign ldir       = ctrl_s.ldir;
  assign ldreg      = ctrl_s.ldreg;
  assign ldcc       = ctrl_s.ldcc;
  assign gatepc     = ctrl_s.gatepc;
  assign gatemdr    = ctrl_s.gatemdr;
  assign gatealu    = ctrl_s.gatealu;
  assign gateshf    = ctrl_s.gateshf;
  assign gatemarmux = ctrl_s.gatemarmux;
  assign mio_en     = ctrl_s.mio_en;
  assign rw         = ctrl_s.rw;
  assign datasize   = ctrl_s.datasize;
  assign lshf       = ctrl_s.lshf;
  assign ben        = ben_q;
  assign state_o    = state_q;
  assign mem_err    = mem_err_q;
  assign illegal_op = illegal_op_q;

endmodule
